// File: rtl/digit_display_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_display_scan_pkg
//  Purpose  : Shared constants for the HH:MM:SS digit scanner: segment
//             patterns, glyph table, scan state encoding and the positions
//             of the decimal-point separators.
//  Revision : 1.0  initial release
// ============================================================================
package digit_display_scan_pkg;

    // Number of physical digits on the display.
    localparam int NUM_DIGITS = 6;

    // Full 8-bit active-low segment words, dp in bit 7.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // 7-bit active-low glyphs (g..a). Entries 10..15 are a dash (segment g only).
    localparam logic [6:0] GLYPH_DASH = 7'h3F;
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH,
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Separator positions: dp on digit 2 (after minutes) and digit 4 (after hours).
    localparam logic [2:0] DP_POS_MIN  = 3'd2;
    localparam logic [2:0] DP_POS_HOUR = 3'd4;

    // Last active digit index for each display mode.
    localparam logic [2:0] LAST_IDX_6 = 3'd5;
    localparam logic [2:0] LAST_IDX_4 = 3'd3;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    // Bank of six BCD-ish digits; entry 0 = S0, entry 5 = H1.
    typedef logic [NUM_DIGITS-1:0][3:0] digit_bank_t;

    // Glyph lookup for one 4-bit value.
    function automatic logic [6:0] glyph_lookup(input logic [3:0] value);
        return GLYPH_TABLE[value];
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_display_scan_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational 4-bit value to active-low 7-segment (g..a)
//             decoder; values above 9 render as a dash.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import digit_display_scan_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    // Table lookup; the table itself carries the dash entries for 10..15.
    always_comb begin
        seg_o = glyph_lookup(value_i);
    end

endmodule
`default_nettype wire

// File: rtl/digit_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : digit_display_scan
//  Purpose  : Time-multiplexed driver for a six-digit common-anode 7-segment
//             display. Snapshots the HH:MM:SS digits at every frame start,
//             lights one digit at a time for DWELL cycles with a one-cycle
//             blank gap between digits, and marks the digit under the edit
//             cursor. Supports 6-digit and 4-digit frames.
//  Options  : CURSOR_BLINK_EN - when defined the cursor digit blinks with a
//             period of 2*BLINK_HALF frames; otherwise its dp is forced on.
//  Revision : 1.0  initial release
// ============================================================================
module digit_display_scan
    import digit_display_scan_pkg::*;
#(
    parameter int DWELL      = 2,
    parameter int BLINK_HALF = 32
)(
    input  logic       key_clk,
    input  logic       reset,
    input  logic       en,
    input  logic       mode,
    input  logic [3:0] H1,
    input  logic [3:0] H0,
    input  logic [3:0] M1,
    input  logic [3:0] M0,
    input  logic [3:0] S1,
    input  logic [3:0] S0,
    input  logic [2:0] cursor,
    output logic [5:0] an,
    output logic [7:0] seg,
    output logic       frame_done
);

    localparam int                 DWELL_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    // Reject nonsensical timing at elaboration.
    if (DWELL < 1 || BLINK_HALF < 1) begin : g_param_check
        $error("digit_display_scan: DWELL and BLINK_HALF must be at least 1");
    end

    scan_state_t        state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               six_q, six_d;
    digit_bank_t        shadow_q, shadow_d;
    logic [2:0]         cursor_q, cursor_d;

    logic [5:0]         an_d;
    logic [7:0]         seg_d;
    logic               frame_done_d;

    logic               w_frame_start;
    logic               w_frame_end;
    logic [2:0]         w_last_idx;
    logic [2:0]         w_last_idx_next;
    logic [3:0]         w_digit;
    logic [6:0]         w_glyph;
    logic               w_dp;
    logic               w_cursor_hit;

    // Sequencer: OFF -> SHOW(0) -> GAP -> SHOW(1) ... wrapping after digit N-1.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dwell_d       = dwell_q;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_last_idx    = six_q ? LAST_IDX_6 : LAST_IDX_4;
        if (!en) begin
            state_d = ST_OFF;
            idx_d   = 3'd0;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d       = ST_SHOW;
                    idx_d         = 3'd0;
                    dwell_d       = '0;
                    w_frame_start = 1'b1;
                end
                ST_SHOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d     = ST_GAP;
                        dwell_d     = '0;
                        w_frame_end = (idx_q == w_last_idx);
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_d = ST_SHOW;
                    dwell_d = '0;
                    if (idx_q == w_last_idx) begin
                        idx_d         = 3'd0;
                        w_frame_start = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 3'd0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // Frame-start snapshot: digits, cursor and digit count are frozen for the frame.
    always_comb begin
        shadow_d        = shadow_q;
        cursor_d        = cursor_q;
        six_d           = six_q;
        if (w_frame_start) begin
            shadow_d = {H1, H0, M1, M0, S1, S0};
            cursor_d = cursor;
            six_d    = mode;
        end
        w_last_idx_next = six_d ? LAST_IDX_6 : LAST_IDX_4;
    end

    // Select the digit that will be lit after this edge.
    always_comb begin
        case (idx_d)
            3'd0:    w_digit = shadow_d[0];
            3'd1:    w_digit = shadow_d[1];
            3'd2:    w_digit = shadow_d[2];
            3'd3:    w_digit = shadow_d[3];
            3'd4:    w_digit = shadow_d[4];
            3'd5:    w_digit = shadow_d[5];
            default: w_digit = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .value_i (w_digit),
        .seg_o   (w_glyph)
    );

`ifdef CURSOR_BLINK_EN
    localparam int                 BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_vis_q, blink_vis_d;

    // Count completed frames and flip the cursor phase every BLINK_HALF of them.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        if (w_frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Blink phase registers; the phase starts visible.
    always_ff @(posedge key_clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end
`endif

    // Pin values for the next cycle, computed from the next state so the pins
    // change on the same edge as the sequencer.
    always_comb begin
        an_d         = 6'h3F;
        seg_d        = SEG_BLANK;
        frame_done_d = w_frame_end;
        w_dp         = (idx_d == DP_POS_MIN) || (six_d && (idx_d == DP_POS_HOUR));
        w_cursor_hit = (cursor_d <= w_last_idx_next) && (cursor_d == idx_d);
        if (state_d == ST_SHOW) begin
            an_d  = ~(6'b000001 << idx_d);
            seg_d = {~w_dp, w_glyph};
`ifdef CURSOR_BLINK_EN
            if (w_cursor_hit && !blink_vis_q) begin
                an_d  = 6'h3F;
                seg_d = SEG_BLANK;
            end
`else
            if (w_cursor_hit) begin
                seg_d[7] = 1'b0;
            end
`endif
        end
    end

    // Sequencer state, frame snapshot and registered display pins.
    always_ff @(posedge key_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OFF;
            idx_q      <= 3'd0;
            dwell_q    <= '0;
            six_q      <= 1'b0;
            shadow_q   <= '0;
            cursor_q   <= 3'd0;
            an         <= 6'h3F;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dwell_q    <= dwell_d;
            six_q      <= six_d;
            shadow_q   <= shadow_d;
            cursor_q   <= cursor_d;
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= frame_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_display_scan
//  Purpose  : Self-checking bench for digit_display_scan. Expected pin values
//             per cycle are queued before each run; a monitor pops one entry
//             for every cycle the display is enabled and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_digit_display_scan;

    localparam int TB_DWELL      = 2;
    localparam int TB_BLINK_HALF = 2;

    typedef struct packed {
        logic [5:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic       key_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       en      = 1'b0;
    logic       mode    = 1'b1;
    logic [3:0] H1, H0, M1, M0, S1, S0;
    logic [2:0] cursor;
    logic [5:0] an;
    logic [7:0] seg;
    logic       frame_done;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp_e;
    logic en_s = 1'b0;

    digit_display_scan #(
        .DWELL      (TB_DWELL),
        .BLINK_HALF (TB_BLINK_HALF)
    ) dut (
        .key_clk    (key_clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .H1         (H1),
        .H0         (H0),
        .M1         (M1),
        .M0         (M0),
        .S1         (S1),
        .S0         (S0),
        .cursor     (cursor),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 key_clk = ~key_clk;

    // Monitor: one expected entry per enabled cycle, compared mid-cycle.
    initial begin : monitor
        forever begin
            @(posedge key_clk);
            en_s = en & reset;
            @(negedge key_clk);
            if (en_s && exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                checks++;
                if (an !== exp_e.an || seg !== exp_e.seg || frame_done !== exp_e.fd) begin
                    errors++;
                    $display("FAIL scan @%0t: an=%b seg=%h frame_done=%b, required an=%b seg=%h frame_done=%b",
                             $time, an, seg, frame_done, exp_e.an, exp_e.seg, exp_e.fd);
                end
            end
        end
    end

    task automatic check_out(input string name, input logic [5:0] ea,
                             input logic [7:0] es, input logic ef);
        checks++;
        if (an !== ea || seg !== es || frame_done !== ef) begin
            errors++;
            $display("FAIL %s: an=%b seg=%h frame_done=%b, required an=%b seg=%h frame_done=%b",
                     name, an, seg, frame_done, ea, es, ef);
        end
    endtask

    // One digit slot: DWELL lit cycles then the gap (frame_done on the last gap).
    task automatic push_digit(input int k, input logic [7:0] s, input bit hide, input bit last);
        for (int c = 0; c < TB_DWELL; c++) begin
            if (hide) exp_q.push_back('{an: 6'h3F, seg: 8'hFF, fd: 1'b0});
            else      exp_q.push_back('{an: ~(6'b000001 << k), seg: s, fd: 1'b0});
        end
        exp_q.push_back('{an: 6'h3F, seg: 8'hFF, fd: last});
    endtask

    // segs packs digit k's segment word in bits [8k+7:8k].
    task automatic push_frame(input int n, input logic [47:0] segs, input bit hide0);
        for (int k = 0; k < n; k++)
            push_digit(k, segs[8*k +: 8], (k == 0) && hide0, k == n - 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge key_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_and_drain(input string name, input int budget);
        en = 1'b1;
        wait_drain(name, budget);
        en = 1'b0;
        repeat (2) @(negedge key_clk);
    endtask

    initial begin : stimulus
        bit   blank_ok;
        {H1, H0, M1, M0, S1, S0} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        cursor = 3'd7;
        mode   = 1'b1;

        // Reset state and idle with en low.
        repeat (3) @(negedge key_clk);
        check_out("reset_state", 6'h3F, 8'hFF, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge key_clk);
        check_out("idle_en0", 6'h3F, 8'hFF, 1'b0);

        // Asynchronous reset in the middle of a SHOW slot.
        en = 1'b1;
        repeat (2) @(negedge key_clk);
        check_out("pre_reset_lit", 6'b111110, 8'h82, 1'b0);
        #2 reset = 1'b0;
        #1 check_out("async_reset", 6'h3F, 8'hFF, 1'b0);
        en = 1'b0;
        @(negedge key_clk);
        reset = 1'b1;
        blank_ok = 1'b1;
        repeat (20) begin
            @(negedge key_clk);
            if (an !== 6'h3F || seg !== 8'hFF || frame_done !== 1'b0) blank_ok = 1'b0;
        end
        checks++;
        if (!blank_ok) begin
            errors++;
            $display("FAIL blank_after_reset: outputs changed with en=0, required an=111111 seg=ff frame_done=0");
        end

        // Six-digit mode, two back-to-back frames of 1,2,3,4,5,6.
        push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}, 1'b0);
        push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}, 1'b0);
        run_and_drain("mode6", 100);

        // Four-digit mode: only digits 0..3, dp on digit 2, 12-cycle frames.
        mode = 1'b0;
        push_frame(4, {16'h0, 8'hB0, 8'h19, 8'h92, 8'h82}, 1'b0);
        push_frame(4, {16'h0, 8'hB0, 8'h19, 8'h92, 8'h82}, 1'b0);
        run_and_drain("mode4", 100);

        // S0 changes mid-frame: visible only from the following frame.
        mode = 1'b1;
        push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}, 1'b0);
        push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'hC0}, 1'b0);
        en = 1'b1;
        repeat (5) @(negedge key_clk);
        S0 = 4'd0;
        run_and_drain("snapshot", 100);

        // Mode change mid-frame takes effect at the next frame.
        push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'hC0}, 1'b0);
        push_frame(4, {16'h0, 8'hB0, 8'h19, 8'h92, 8'hC0}, 1'b0);
        en = 1'b1;
        repeat (5) @(negedge key_clk);
        mode = 1'b0;
        run_and_drain("mode_switch", 100);
        mode = 1'b1;

        // en drops during digit 1; restart at digit 0 with a fresh snapshot.
        push_digit(0, 8'hC0, 1'b0, 1'b0);
        exp_q.push_back('{an: 6'b111101, seg: 8'h92, fd: 1'b0});
        en = 1'b1;
        repeat (4) @(negedge key_clk);
        en = 1'b0;
        @(negedge key_clk);
        check_out("en_drop_blank", 6'h3F, 8'hFF, 1'b0);
        wait_drain("en_drop", 4);
        S0 = 4'd7;
        push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'hF8}, 1'b0);
        run_and_drain("restart", 100);

        // Value above 9 renders as a dash.
        H1 = 4'hC;
        S0 = 4'd0;
        push_frame(6, {8'hBF, 8'h24, 8'hB0, 8'h19, 8'h92, 8'hC0}, 1'b0);
        run_and_drain("dash", 100);

`ifndef CURSOR_BLINK_EN
        // Static cursor marker: dp forced on the cursor digit when cursor < N.
        cursor = 3'd5;
        push_frame(6, {8'h3F, 8'h24, 8'hB0, 8'h19, 8'h92, 8'hC0}, 1'b0);
        run_and_drain("cursor5", 100);
        cursor = 3'd1;
        push_frame(6, {8'hBF, 8'h24, 8'hB0, 8'h19, 8'h12, 8'hC0}, 1'b0);
        run_and_drain("cursor1", 100);
        mode   = 1'b0;
        cursor = 3'd4;
        push_frame(4, {16'h0, 8'hB0, 8'h19, 8'h92, 8'hC0}, 1'b0);
        run_and_drain("cursor4_mode4", 100);
        cursor = 3'd3;
        push_frame(4, {16'h0, 8'h30, 8'h19, 8'h92, 8'hC0}, 1'b0);
        run_and_drain("cursor3_mode4", 100);
        mode = 1'b1;
`else
        // Blinking cursor on digit 0: frames 3-4 hide it, frames 5-6 show it.
        reset = 1'b0;
        @(negedge key_clk);
        reset = 1'b1;
        @(negedge key_clk);
        {H1, H0, M1, M0, S1, S0} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        cursor = 3'd0;
        mode   = 1'b1;
        for (int f = 1; f <= 6; f++)
            push_frame(6, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}, (f == 3) || (f == 4));
        run_and_drain("blink", 200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
